// File: rtl/mult8_share_arb_pkg.sv
// Types and widths shared by the mult8_share_arb slice.
`include "mult8_defs.svh"

package mult8_share_arb_pkg;

    localparam int unsigned OP_W   = `MULT8_OP_W;
    localparam int unsigned PROD_W = `MULT8_PROD_W;

    typedef enum logic [1:0] {
        StIdle = `MULT8_ST_IDLE,
        StCalc = `MULT8_ST_CALC,
        StResp = `MULT8_ST_RESP
    } state_e;

endpackage

// File: rtl/mult8_defs.svh
// Shared encodings and widths for the mult8_share_arb slice (RTL and bench).
`ifndef MULT8_DEFS_SVH
`define MULT8_DEFS_SVH

`define MULT8_ST_IDLE 2'd0
`define MULT8_ST_CALC 2'd1
`define MULT8_ST_RESP 2'd2

`define MULT8_OP_W   8
`define MULT8_PROD_W 16

`endif

// File: rtl/mult8_rr_pick.sv
// One-hot request picker. MULT8_ARB_RR_EN selects round-robin from ptr+1,
// otherwise fixed priority with the lowest index winning.
module mult8_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic        found;
    int unsigned idx;

`ifdef MULT8_ARB_RR_EN
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Rotate so that bit 0 is the request just after the pointer.
        dbl       = {req, req} >> (32'(ptr) + 32'd1);
        rot       = dbl[NREQ-1:0];
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = (unsigned'(i) + 32'(ptr) + 32'd1) % NREQ;
            end
        end
        if (found) begin
            grant_idx = ID_W'(idx);
            grant     = NREQ'(1) << idx;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = unsigned'(i);
            end
        end
        if (found) begin
            grant_idx = ID_W'(idx);
            grant     = NREQ'(1) << idx;
        end
    end
`endif

endmodule

// File: rtl/multiply8_signed.sv
// Combinational signed 8x8 -> 16 multiplier shared by the arbiter.
module multiply8_signed (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] product
);

    assign product = a * b;

endmodule

// File: rtl/mult8_share_arb.sv
// Shares one multiply8_signed among NREQ valid/ready requesters, one op in flight.
// Build macro MULT8_ARB_RR_EN enables round-robin arbitration (default: fixed priority).
module mult8_share_arb
    import mult8_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [PROD_W-1:0]    rsp_product,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 rsp_ready
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]   sel_a, sel_b;
    logic [ID_W-1:0]   id_q;
    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] product;
    logic              rsp_valid_q;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   ptr;
    logic              accept;

    mult8_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    multiply8_signed u_mul (
        .a       (a_q),
        .b       (b_q),
        .product (product)
    );

    assign accept = (state_q == StIdle) && (|grant);

`ifdef MULT8_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(NREQ - 1);
        end else if (accept) begin
            ptr_q <= grant_idx;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = ID_W'(NREQ - 1);
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*8 +: 8];
                sel_b = req_b[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                // Gate on reset so the grant drops the instant reset rises.
                if (!reset) begin
                    req_ready = grant;
                end
                if (|grant) begin
                    state_d = StCalc;
                end
            end
            StCalc: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            prod_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= grant_idx;
            end
            if (state_q == StCalc) begin
                prod_q      <= product;
                rsp_valid_q <= 1'b1;
            end else if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = prod_q;
    assign rsp_id      = id_q;

endmodule

// File: tb/tb_mult8_share_arb.sv
// Scoreboard bench for mult8_share_arb; honours MULT8_ARB_RR_EN like the RTL.
`include "mult8_defs.svh"

module tb_mult8_share_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_product;
    logic [1:0]  rsp_id;
    logic        rsp_ready;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [1:0] m_st     = `MULT8_ST_IDLE;
    int         m_ptr    = 3;
    bit [3:0]   acc      = '0;

    mult8_share_arb #(
        .NREQ (4),
        .ID_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Search from ptr+1; fixed priority is the same search with ptr parked at 3.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (ptr + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int       e;
            logic [3:0] er;
            exp_t     ent;
            e  = pick(req_valid, m_ptr);
            er = '0;
            if (m_st == `MULT8_ST_IDLE && e >= 0) er[e] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(er));
            check("onehot0", 32'($onehot0(req_ready)), 32'd1);
            check("rsp_valid", 32'(rsp_valid), 32'(m_st == `MULT8_ST_RESP));
            case (m_st)
                `MULT8_ST_IDLE: begin
                    if (e >= 0) begin
                        ent.id   = 2'(e);
                        ent.prod = ref_mul(req_a[8*e +: 8], req_b[8*e +: 8]);
                        exp_q.push_back(ent);
`ifdef MULT8_ARB_RR_EN
                        m_ptr = e;
`endif
                        acc[e] = 1'b1;
                        m_st   = `MULT8_ST_CALC;
                    end
                end
                `MULT8_ST_CALC: m_st = `MULT8_ST_RESP;
                default: begin
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            check("sb_underflow", 32'd0, 32'd1);
                        end else begin
                            ent = exp_q.pop_front();
                            check("sb_product", 32'(rsp_product), 32'(ent.prod));
                            check("sb_id", 32'(rsp_id), 32'(ent.id));
                        end
                        m_st = `MULT8_ST_IDLE;
                    end
                end
            endcase
        end
    end

    task automatic model_reset();
        m_st  = `MULT8_ST_IDLE;
        m_ptr = 3;
        acc   = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_one(input int rq, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_prod);
        @(posedge clk);
        #1;
        req_valid[rq]     = 1'b1;
        req_a[8*rq +: 8]  = a;
        req_b[8*rq +: 8]  = b;
        @(negedge clk);
        check("one_grant", 32'(req_ready), 32'(4'b1 << rq));
        @(posedge clk);
        #1 req_valid[rq] = 1'b0;
        @(negedge clk);
        check("one_lat_calc", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("one_lat_resp", 32'(rsp_valid), 32'd1);
        check("one_product", 32'(rsp_product), 32'(exp_prod));
        check("one_id", 32'(rsp_id), 32'(rq));
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  corner_a[4] = '{8'h80, 8'h80, 8'h02, 8'h00};
    logic [7:0]  corner_b[4] = '{8'h80, 8'h7F, 8'hFE, 8'h80};
    logic [15:0] corner_p[4] = '{16'h4000, 16'hC080, 16'hFFFC, 16'h0000};
`ifdef MULT8_ARB_RR_EN
    int exp_ids[5] = '{0, 1, 2, 3, 0};
`else
    int exp_ids[5] = '{0, 0, 0, 0, 0};
`endif

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_product", 32'(rsp_product), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Single request and sign corners.
        do_one(0, 8'hFF, 8'hFF, 16'h0001);
        for (int i = 0; i < 4; i++) do_one(1, corner_a[i], corner_b[i], corner_p[i]);

        // Backpressure: response held while a competitor waits.
        @(posedge clk);
        #1;
        rsp_ready      = 1'b0;
        req_valid      = 4'b0100;
        req_a[23:16]   = 8'h05;
        req_b[23:16]   = 8'hFD;
        @(negedge clk);
        check("bp_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        req_valid      = 4'b1000;
        req_a[31:24]   = 8'h02;
        req_b[31:24]   = 8'h02;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check("bp_product", 32'(rsp_product), 32'hFFF1);
            check("bp_id", 32'(rsp_id), 32'd2);
            check("bp_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'h8);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp();
        @(posedge clk);
        #1;

        // Contention from a fresh reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'h10;
        end
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                check("cont_id", 32'(rsp_id), 32'(exp_ids[n]));
                check("cont_product", 32'(rsp_product), 32'h10 * 32'(exp_ids[n] + 1));
                n++;
            end
        end
        check("cont_count", 32'(n), 32'd5);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Reset during CALC.
        req_valid    = 4'b0010;
        req_a[15:8]  = 8'h03;
        req_b[15:8]  = 8'h05;
        @(negedge clk);
        check("rc_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        req_valid = 4'b0101;
        #2 reset = 1'b1;
        #1;
        check("rc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rc_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rc_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 4'b0101;
        @(negedge clk);
        check("rc_first_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = '0;
        acc = '0;
        wait_rsp();
        @(posedge clk);
        #1;

        // Random traffic; the monitor checks every cycle.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    acc[i]          = 1'b0;
                    req_valid[i]    = 1'($urandom_range(0, 1));
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i]    = 1'b1;
                        req_a[8*i +: 8] = 8'($urandom);
                        req_b[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult8_share_arb.md
Name: mult8_share_arb

Overview:
Shares one combinational multiply8_signed instance among NREQ requesters. Each requester presents a signed 8x8 operand pair with a valid/ready handshake. The block arbitrates between requesters, registers the operands, captures the 16-bit signed product and returns it with the requester's id over a valid/ready response port. It sits between the DSP-side clients and the single multiplier datapath. Only one operation is outstanding at a time.

Parameters:
NREQ, 4, number of requesters (2..8).
ID_W, 2, width of the response id; 2**ID_W >= NREQ is required.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  NREQ  per-requester request valid.
req_a  input  8*NREQ  multiplicand, requester i at [8*i+7:8*i], two's complement.
req_b  input  8*NREQ  multiplier, same packing as req_a.
req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
rsp_valid  output  1  response valid.
rsp_product  output  16  signed product a*b.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0, operand regs=0, RR pointer=NREQ-1 (requester 0 wins first).
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is combinational: the one-hot grant of the arbiter over req_valid. It is 0 when no request is pending.
  - A transfer happens when req_valid[i] and req_ready[i] are both high.
  - On a transfer edge: latch a_i and b_i into the operand regs, latch i into the id reg, update the RR pointer to i, go to CALC.
- CALC:
  - req_ready=0.
  - The operand regs drive multiply8_signed.
  - Next edge: rsp_product <= product, rsp_valid <= 1, go to RESP.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_product and rsp_id are held stable until rsp_ready=1.
  - On the edge where rsp_valid and rsp_ready are both high: rsp_valid <= 0, go to IDLE.
- Latency: accept edge N produces rsp_valid high after edge N+1. Minimum issue interval is 3 cycles.
- Arithmetic: full 16-bit two's-complement product, with no overflow possible. 0x80*0x80 = +16384 = 0x4000.
- Requester rule: a_i and b_i must stay stable while req_valid[i] is high and not yet accepted. A requester may drop valid before it is granted; the block takes no action on that.
- Simultaneous events:
  - A new req_valid arriving during CALC or RESP waits; there is no queueing inside the block.
  - rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation aborts any in-flight operand or response. No response is issued for it.
- Idle power: operand regs hold their last value; the product is don't-care outside CALC.

Optional Feature:
MULT8_ARB_RR_EN:
- Defined: round-robin arbitration. The search starts at (pointer+1) mod NREQ and the first asserted req_valid wins. This gives starvation-free service.
- Undefined: fixed priority, where the lowest index wins. The RR pointer logic is removed and reset ordering is unchanged (requester 0 wins).

Decomposition:
- Shared constants include (`define header, included by the RTL and the bench):
  - state encodings MULT8_ST_IDLE=2'd0, MULT8_ST_CALC=2'd1, MULT8_ST_RESP=2'd2;
  - operand width 8 and product width 16.
- Sub-module mult8_rr_pick: a purely combinational one-hot picker with inputs req[NREQ] and ptr[ID_W], outputs grant[NREQ] and grant_idx[ID_W]. It contains the MULT8_ARB_RR_EN selection.
- multiply8_signed is instantiated unchanged.

Test Plan:
1. Single request, rq0 a=0xFF b=0xFF -> req_ready[0] in the same cycle. rsp_valid rises 2 edges after the request, with product=0x0001 and id=0.
2. Sign corners, one at a time on rq1:
   - 0x80*0x80 -> 0x4000;
   - 0x80*0x7F -> 0xC080;
   - 0x02*0xFE -> 0xFFFC;
   - 0x00*0x80 -> 0x0000.
   All responses must carry id=1.
3. Contention, all 4 valid continuously (a=i+1, b=0x10), rsp_ready=1:
   - with RR_EN, ids are 0,1,2,3,0 with products 0x0010, 0x0020, 0x0030, 0x0040;
   - without RR_EN, id=0 every time.
4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_product and rsp_id are stable and req_ready=0 throughout. Raise rsp_ready -> IDLE next edge, and the next grant follows in that IDLE cycle.
5. Async reset asserted during CALC (between edges) -> rsp_valid=0 and req_ready=0 immediately, with no response after release. The first grant after reset goes to requester 0.
6. Invariant checks over 10k random cycles:
   - req_ready is onehot0;
   - req_ready is nonzero only in IDLE;
   - rsp_product equals a signed reference model of the granted operands.
